// File: rtl/multicycle_ctrl_v2_if.sv
// Controller <-> datapath/memory signal bundle for the multicycle RISC core.
// master: the control FSM (drives strobes), slave: datapath and memories.
interface multicycle_ctrl_v2_if #(
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
);
  logic [INSTR_W-1:0] instr;
  logic               imem_ready;
  logic               dmem_ready;
  logic               alu_zero;
  logic               alu_neg;
  logic               imem_req;
  logic               ir_latch;
  logic               pc_latch;
  logic [1:0]         pc_mux_sel;
  logic               rs1_sel;
  logic [1:0]         rs2_sel;
  logic               a_latch;
  logic               b_latch;
  logic               alu_latch;
  logic [1:0]         alu_sel;
  logic               reg_wr_en;
  logic               rd_sel;
  logic               wrd_sel;
  logic               dmem_req;
  logic               dmem_we;
  logic               halted;
  logic               illegal_instr;
  logic               bus_err;
  logic [CNT_W-1:0]   retired_cnt;

  modport master (
    input  instr, imem_ready, dmem_ready, alu_zero, alu_neg,
    output imem_req, ir_latch, pc_latch, pc_mux_sel, rs1_sel, rs2_sel,
           a_latch, b_latch, alu_latch, alu_sel, reg_wr_en, rd_sel, wrd_sel,
           dmem_req, dmem_we, halted, illegal_instr, bus_err, retired_cnt
  );

  modport slave (
    output instr, imem_ready, dmem_ready, alu_zero, alu_neg,
    input  imem_req, ir_latch, pc_latch, pc_mux_sel, rs1_sel, rs2_sel,
           a_latch, b_latch, alu_latch, alu_sel, reg_wr_en, rd_sel, wrd_sel,
           dmem_req, dmem_we, halted, illegal_instr, bus_err, retired_cnt
  );
endinterface

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle control FSM for the 16-bit RISC datapath.
// state  | meaning
// RESET  | post-reset idle cycle, all strobes low
// FETCH  | request imem, latch IR on imem_ready
// DECODE | load A/B, PC+1 for non-branch opcodes
// EXE    | ALU operation into ALU-out register
// MEM    | data memory access, held until dmem_ready
// WB     | register file write-back
// BR     | PC update from branch condition
// HALT   | stopped by HALT opcode
// TRAP   | stopped by illegal opcode or handshake timeout
module multicycle_ctrl_v2 #(
  parameter int INSTR_W  = 16,
  parameter int OPC_W    = 3,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input logic                clk,
  input logic                rst,
  multicycle_ctrl_v2_if.master bus
);
  // opcode width can never exceed the instruction word
  localparam int OW     = (OPC_W < INSTR_W) ? OPC_W : INSTR_W;
  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXE, S_MEM, S_WB, S_BR, S_HALT, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    K_RR, K_RI, K_LOAD, K_STORE, K_BEQ, K_BNE, K_BLT, K_JMP, K_HALT, K_ILL
  } kind_t;

  // with a 3-bit opcode bit 3 is always zero, so HALT/illegal never decode
  function automatic kind_t classify(input logic [3:0] opc);
    kind_t k;
    if (opc[3]) begin
      k = (opc == 4'hF) ? K_HALT : K_ILL;
    end else begin
      case (opc[2:0])
        3'd0:    k = K_RR;
        3'd1:    k = K_RI;
        3'd2:    k = K_LOAD;
        3'd3:    k = K_STORE;
        3'd4:    k = K_BEQ;
        3'd5:    k = K_BNE;
        3'd6:    k = K_BLT;
        default: k = K_JMP;
      endcase
    end
    return k;
  endfunction

  state_t            state;
  logic [OW-1:0]     opc_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  cnt_q;
  logic              illegal_q;
  logic              bus_err_q;
  kind_t             kind;
  logic              timeout_hit;
  logic              taken;

  assign kind        = classify(4'(opc_q));
  assign timeout_hit = (MAX_WAIT != 0) && (wait_cnt == WAIT_W'(MAX_WAIT));

  always_comb begin
    case (kind)
      K_BEQ:   taken = bus.alu_zero;
      K_BNE:   taken = !bus.alu_zero;
      K_BLT:   taken = bus.alu_neg;
      K_JMP:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // state sequencing, IR opcode capture, wait timer, retire counter, sticky traps
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RESET;
      opc_q     <= '0;
      wait_cnt  <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      // any state other than a continuing wait leaves the timer cleared
      wait_cnt <= '0;
      case (state)
        S_RESET: state <= S_FETCH;
        S_FETCH: begin
          if (bus.imem_ready) begin
            opc_q <= bus.instr[OW-1:0];
            state <= S_DECODE;
          end else if (timeout_hit) begin
            state     <= S_TRAP;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          case (kind)
            K_JMP:   state <= S_BR;
            K_HALT:  state <= S_HALT;
            K_ILL: begin
              state     <= S_TRAP;
              illegal_q <= 1'b1;
            end
            default: state <= S_EXE;
          endcase
        end
        S_EXE: begin
          case (kind)
            K_RR, K_RI:      state <= S_WB;
            K_LOAD, K_STORE: state <= S_MEM;
            default:         state <= S_BR;
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            if (kind == K_STORE) begin
              state <= S_FETCH;
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              state <= S_WB;
            end
          end else if (timeout_hit) begin
            state     <= S_TRAP;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB, S_BR: begin
          state <= S_FETCH;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_TRAP;
      endcase
    end
  end

  // Moore strobe decode from state and IR opcode; ir_latch and branch select follow inputs
  always_comb begin
    bus.imem_req   = 1'b0;
    bus.ir_latch   = 1'b0;
    bus.pc_latch   = 1'b0;
    bus.pc_mux_sel = 2'b00;
    bus.rs1_sel    = 1'b0;
    bus.rs2_sel    = 2'b00;
    bus.a_latch    = 1'b0;
    bus.b_latch    = 1'b0;
    bus.alu_latch  = 1'b0;
    bus.alu_sel    = 2'b00;
    bus.reg_wr_en  = 1'b0;
    bus.rd_sel     = 1'b0;
    bus.wrd_sel    = 1'b0;
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.halted     = 1'b0;
    case (state)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_latch = bus.imem_ready;
      end
      S_DECODE: begin
        bus.a_latch = 1'b1;
        bus.b_latch = 1'b1;
        if (kind == K_RI || kind == K_LOAD || kind == K_STORE) bus.rs2_sel = 2'b01;
        if (kind == K_RR || kind == K_RI || kind == K_LOAD || kind == K_STORE) bus.pc_latch = 1'b1;
      end
      S_EXE: begin
        bus.alu_latch = 1'b1;
        case (kind)
          K_RR:                   bus.alu_sel = 2'b01;
          K_RI, K_LOAD, K_STORE:  bus.alu_sel = 2'b00;
          default:                bus.alu_sel = 2'b11;
        endcase
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (kind == K_STORE);
      end
      S_WB: begin
        bus.reg_wr_en = 1'b1;
        bus.rd_sel    = (kind == K_RR);
        bus.wrd_sel   = (kind == K_LOAD);
      end
      S_BR: begin
        bus.pc_latch   = 1'b1;
        bus.pc_mux_sel = taken ? 2'b01 : 2'b00;
      end
      S_HALT, S_TRAP: bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.illegal_instr = illegal_q;
  assign bus.bus_err       = bus_err_q;
  assign bus.retired_cnt   = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Scoreboard bench for multicycle_ctrl_v2 (4-bit opcode map, 4-cycle wait limit).
module tb_multicycle_ctrl_v2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_v2_if #(.INSTR_W(16), .CNT_W(16)) bus ();

  multicycle_ctrl_v2 #(.INSTR_W(16), .OPC_W(4), .MAX_WAIT(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // off = cycles since FETCH entry (FETCH cycle itself is 0)
  typedef struct packed {
    logic [7:0]  off;
    logic        wr, rd, wrd, dreq, dwe, pcl;
    logic [1:0]  pcm;
    logic        h, il, be;
    logic [15:0] cnt;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic ev_t mk(input int off, input logic wr, input logic rd, input logic wrd,
                             input logic dreq, input logic dwe, input logic pcl,
                             input logic [1:0] pcm, input logic h, input logic il, input logic be);
    ev_t e;
    e.off = 8'(off); e.wr = wr; e.rd = rd; e.wrd = wrd; e.dreq = dreq; e.dwe = dwe;
    e.pcl = pcl; e.pcm = pcm; e.h = h; e.il = il; e.be = be; e.cnt = exp_cnt;
    return e;
  endfunction

  function automatic logic [63:0] outvec();
    return 64'({bus.imem_req, bus.ir_latch, bus.pc_latch, bus.pc_mux_sel, bus.rs1_sel,
                bus.rs2_sel, bus.a_latch, bus.b_latch, bus.alu_latch, bus.alu_sel,
                bus.reg_wr_en, bus.rd_sel, bus.wrd_sel, bus.dmem_req, bus.dmem_we,
                bus.halted, bus.illegal_instr, bus.bus_err, bus.retired_cnt});
  endfunction

  // monitor: every WB, MEM, BR cycle and every entry to HALT/TRAP pops one expectation
  int   mon_off = 0;
  logic prev_req = 1'b0;
  logic prev_halt = 1'b0;
  ev_t  mon_act, mon_exp;
  always @(negedge clk) begin
    if (bus.imem_req === 1'b1 && !prev_req) mon_off = 0;
    else mon_off++;
    prev_req = (bus.imem_req === 1'b1);
    if (bus.reg_wr_en === 1'b1 || bus.dmem_req === 1'b1 ||
        (bus.pc_latch === 1'b1 && bus.a_latch !== 1'b1) ||
        (bus.halted === 1'b1 && !prev_halt)) begin
      mon_act.off = 8'(mon_off);
      mon_act.wr = bus.reg_wr_en; mon_act.rd = bus.rd_sel; mon_act.wrd = bus.wrd_sel;
      mon_act.dreq = bus.dmem_req; mon_act.dwe = bus.dmem_we; mon_act.pcl = bus.pc_latch;
      mon_act.pcm = bus.pc_mux_sel; mon_act.h = bus.halted; mon_act.il = bus.illegal_instr;
      mon_act.be = bus.bus_err; mon_act.cnt = bus.retired_cnt;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL event_unexpected actual=%0h required=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("event", 64'(mon_act), 64'(mon_exp));
      end
    end
    prev_halt = (bus.halted === 1'b1);
  end

  // holds rst for n cycles checking the quiet RESET state, ends at the first FETCH negedge
  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("reset_outputs", outvec(), 64'd0);
    end
    rst = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    chk("fetch_after_reset", 64'(bus.imem_req), 64'd1);
  endtask

  // called at a FETCH negedge; returns at the negedge of the following FETCH
  task automatic issue(input logic [3:0] opc, input logic z, input logic n,
                       input int dwait, input int ncyc);
    int mc;
    mc = 0;
    bus.instr = {12'h000, opc};
    bus.alu_zero = z;
    bus.alu_neg = n;
    bus.dmem_ready = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (bus.dmem_req === 1'b1) begin
        bus.dmem_ready = (mc >= dwait);
        mc++;
      end else begin
        bus.dmem_ready = 1'b0;
      end
    end
  endtask

  // expected events from the opcode latency table, zero imem wait states
  task automatic run_instr(input logic [3:0] opc, input logic z, input logic n, input int dwait);
    int   lat;
    logic tk;
    lat = 4;
    case (opc)
      4'd0, 4'd1: exp_q.push_back(mk(3, 1, (opc == 4'd0), 0, 0, 0, 0, 2'b00, 0, 0, 0));
      4'd2: begin
        for (int k = 0; k <= dwait; k++) exp_q.push_back(mk(3 + k, 0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0));
        exp_q.push_back(mk(4 + dwait, 1, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
        lat = 5 + dwait;
      end
      4'd3: begin
        for (int k = 0; k <= dwait; k++) exp_q.push_back(mk(3 + k, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0));
        lat = 4 + dwait;
      end
      4'd7: begin
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0, 0));
        lat = 3;
      end
      default: begin
        tk = (opc == 4'd4) ? z : (opc == 4'd5) ? !z : n;
        exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 1, tk ? 2'b01 : 2'b00, 0, 0, 0));
      end
    endcase
    issue(opc, z, n, dwait, lat);
    exp_cnt = exp_cnt + 16'd1;
  endtask

  initial begin
    bus.instr = '0;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    bus.alu_zero = 1'b0;
    bus.alu_neg = 1'b0;
    do_reset(2);

    run_instr(4'd0, 0, 0, 0);   // RR
    run_instr(4'd1, 0, 0, 0);   // RI
    run_instr(4'd2, 0, 0, 3);   // LOAD, 3 stall cycles
    run_instr(4'd4, 1, 0, 0);   // BEQ taken
    run_instr(4'd4, 0, 0, 0);   // BEQ not taken
    run_instr(4'd5, 0, 0, 0);   // BNE taken
    run_instr(4'd6, 0, 1, 0);   // BLT taken
    run_instr(4'd6, 0, 0, 0);   // BLT not taken
    run_instr(4'd7, 0, 0, 0);   // JMP
    run_instr(4'd3, 0, 0, 0);   // STORE
    run_instr(4'd3, 0, 0, 2);   // STORE, 2 stall cycles
    chk("retired_cnt", 64'(bus.retired_cnt), 64'(exp_cnt));

    // reset in the middle of a stalled STORE
    exp_q.push_back(mk(3, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0));
    exp_q.push_back(mk(4, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0));
    bus.instr = 16'h0003;
    bus.dmem_ready = 1'b0;
    repeat (4) @(negedge clk);
    do_reset(2);

    // imem never ready: 5 FETCH cycles then TRAP with bus_err
    exp_q.push_back(mk(5, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1));
    bus.imem_ready = 1'b0;
    repeat (5) @(negedge clk);
    repeat (4) begin
      @(negedge clk);
      chk("trap_halted", 64'(bus.halted), 64'd1);
      chk("trap_bus_err", 64'(bus.bus_err), 64'd1);
    end
    do_reset(1);

    // illegal opcode 1010
    exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0));
    issue(4'hA, 0, 0, 0, 2);
    repeat (3) begin
      @(negedge clk);
      chk("illegal_hold", 64'({bus.halted, bus.illegal_instr, bus.bus_err}), 64'b110);
    end
    do_reset(1);

    // HALT after one retired RR; counter must stay frozen
    run_instr(4'd0, 0, 0, 0);
    exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0));
    issue(4'hF, 0, 0, 0, 2);
    repeat (5) @(negedge clk);
    chk("halt_state", 64'({bus.halted, bus.illegal_instr, bus.bus_err}), 64'b100);
    chk("halt_cnt_frozen", 64'(bus.retired_cnt), 64'(exp_cnt));

    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
